// File: rtl/dmem_dma_ctrl.sv
// dmem_dma_ctrl: block-copy DMA engine sharing a single-port data memory
// with the CPU. The CPU always wins the port. The DMA moves one byte per
// READ/WRITE pair, using only the cycles in which the CPU leaves the port idle.
module dmem_dma_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    // CPU load/store path
    input  logic              cpuReq,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuDataIn,
    input  logic              cpuMemOp,
    output logic [DATA_W-1:0] cpuDataOut,
    // DMA control
    input  logic              start,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    // Data memory port
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memOp,
    input  logic [DATA_W-1:0] memDataOut
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   cur_src_q,   cur_src_d;
    logic [ADDR_W-1:0]   cur_dst_q,   cur_dst_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   buffer_q,    buffer_d;
    logic                dma_owns;

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of the others, independent of statement order.
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            buffer_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            buffer_q    <= buffer_d;
        end
    end

    // Next-state logic: the DMA advances only in cycles the CPU leaves free.
    always_comb begin
        // NOTE: every output gets a hold default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        buffer_d    = buffer_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_src_d   = srcAddr;
                    cur_dst_d   = dstAddr;
                    remaining_d = len;
                    state_d     = (len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (!cpuReq) begin
                    buffer_d = memDataOut;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!cpuReq) begin
                    cur_src_d   = cur_src_q + 1'b1;
                    cur_dst_d   = cur_dst_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == LEN_W'(1)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign dma_owns = !cpuReq && (state_q == ST_READ || state_q == ST_WRITE);

    // Port arbiter: CPU by default, DMA only in its free READ/WRITE cycles;
    // writes are suppressed entirely while reset is asserted.
    always_comb begin
        memAddr   = cpuAddr;
        memDataIn = cpuDataIn;
        memOp     = cpuMemOp & cpuReq;
        if (dma_owns) begin
            memDataIn = buffer_q;
            if (state_q == ST_READ) begin
                memAddr = cur_src_q;
                memOp   = 1'b0;
            end else begin
                memAddr = cur_dst_q;
                memOp   = 1'b1;
            end
        end
        if (!RST_N) begin
            memOp = 1'b0;
        end
    end

    assign cpuDataOut = memDataOut;
    assign busy       = RST_N && (state_q != ST_IDLE);
    assign done       = RST_N && (state_q == ST_DONE);

endmodule

// File: tb/tb_dmem_dma_ctrl.sv
// Testbench for dmem_dma_ctrl: a behavioural memory sits on the port, and a
// reference image of that memory is updated from the copy rules (byte-wise
// forward copy, CPU priority, one free cycle per READ or WRITE).
module tb_dmem_dma_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       cpuReq;
    logic [7:0] cpuAddr;
    logic [7:0] cpuDataIn;
    logic       cpuMemOp;
    logic [7:0] cpuDataOut;
    logic       start;
    logic [7:0] srcAddr;
    logic [7:0] dstAddr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] memAddr;
    logic [7:0] memDataIn;
    logic       memOp;
    logic [7:0] memDataOut;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int checks;
    int errors;

    dmem_dma_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .cpuReq     (cpuReq),
        .cpuAddr    (cpuAddr),
        .cpuDataIn  (cpuDataIn),
        .cpuMemOp   (cpuMemOp),
        .cpuDataOut (cpuDataOut),
        .start      (start),
        .srcAddr    (srcAddr),
        .dstAddr    (dstAddr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .memAddr    (memAddr),
        .memDataIn  (memDataIn),
        .memOp      (memOp),
        .memDataOut (memDataOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory: combinational read, write on posedge.
    assign memDataOut = mem[memAddr];
    always @(posedge CLK) begin
        if (memOp === 1'b1) mem[memAddr] <= memDataIn;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cpu_store(input logic [7:0] a, input logic [7:0] d);
        cpuReq    = 1'b1;
        cpuMemOp  = 1'b1;
        cpuAddr   = a;
        cpuDataIn = d;
        @(posedge CLK); #1;
        ref_mem[a] = d;
        cpuReq     = 1'b0;
        cpuMemOp   = 1'b0;
    endtask

    task automatic check_mem_image(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    // One transfer: the CPU may steal the port either in a directed window
    // [st_at, st_at+st_n) or at random (rnd_pct percent of cycles). done is
    // expected in the cycle after the 2*len-th free cycle.
    task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int rnd_pct, input int st_at, input int st_n,
                            input int restart_at, input int exp_cycles, input string tag);
        int         free_cnt;
        int         cyc;
        int         len_i;
        logic       fin;
        logic       exp_done;
        logic [7:0] buf_m;
        logic [7:0] a;
        len_i    = int'(l);
        free_cnt = 0;
        cyc      = 0;
        fin      = 1'b0;
        buf_m    = 8'h00;
        srcAddr  = s;
        dstAddr  = d;
        len      = l;
        start    = 1'b1;
        cpuReq   = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int n = 1; n <= 2000 && !fin; n++) begin
            if (n >= st_at && n < st_at + st_n) begin
                cpuReq    = 1'b1;
                cpuMemOp  = (n == st_at);
                cpuAddr   = (n == st_at) ? 8'h80 : 8'h20;
                cpuDataIn = 8'h5A;
            end else begin
                cpuReq    = ($urandom_range(99) < rnd_pct);
                cpuMemOp  = 1'($urandom_range(1));
                cpuAddr   = 8'($urandom);
                cpuDataIn = 8'($urandom);
            end
            if (n == restart_at) begin
                start   = 1'b1;
                srcAddr = 8'($urandom);
                dstAddr = 8'($urandom);
                len     = 8'($urandom_range(3));
            end else begin
                start = 1'b0;
            end
            #1;
            exp_done = (free_cnt == 2 * len_i);
            check({tag, "_done"}, done, exp_done);
            check({tag, "_busy"}, busy, 1'b1);
            if (cpuReq) begin
                check({tag, "_cpu_addr"}, memAddr, cpuAddr);
                check({tag, "_cpu_op"}, memOp, cpuMemOp);
                if (!cpuMemOp) check({tag, "_cpu_rd"}, cpuDataOut, ref_mem[cpuAddr]);
            end else if (!exp_done) begin
                if (free_cnt % 2 == 0) begin
                    a = s + 8'(free_cnt / 2);
                    check({tag, "_rd_addr"}, memAddr, a);
                    check({tag, "_rd_op"}, memOp, 1'b0);
                end else begin
                    a = d + 8'(free_cnt / 2);
                    check({tag, "_wr_addr"}, memAddr, a);
                    check({tag, "_wr_op"}, memOp, 1'b1);
                    check({tag, "_wr_data"}, memDataIn, buf_m);
                end
            end else begin
                check({tag, "_idle_op"}, memOp, 1'b0);
            end
            // Reference update for what this cycle commits at the edge.
            if (cpuReq && cpuMemOp) begin
                ref_mem[cpuAddr] = cpuDataIn;
            end else if (!cpuReq && !exp_done) begin
                if (free_cnt % 2 == 0) buf_m = ref_mem[s + 8'(free_cnt / 2)];
                else                   ref_mem[d + 8'(free_cnt / 2)] = buf_m;
                free_cnt++;
            end
            if (exp_done) begin
                fin = 1'b1;
                cyc = n;
            end
            @(posedge CLK); #1;
        end
        start  = 1'b0;
        cpuReq = 1'b0;
        #1;
        check({tag, "_finished"}, fin, 1'b1);
        if (exp_cycles >= 0) check({tag, "_latency"}, cyc, exp_cycles);
        check({tag, "_post_busy"}, busy, 1'b0);
        check({tag, "_post_done"}, done, 1'b0);
        check_mem_image({tag, "_mem"});
    endtask

    initial begin
        logic [7:0] pat [4];
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        cpuReq    = 1'b1;
        cpuMemOp  = 1'b1;
        cpuAddr   = 8'h33;
        cpuDataIn = 8'hEE;
        start     = 1'b1;
        srcAddr   = 8'h00;
        dstAddr   = 8'h00;
        len       = 8'h04;
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;

        // Reset: no write, no busy/done, even with a CPU store and start held.
        #2;
        check("rst_memop", memOp, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        start  = 1'b0;
        cpuReq = 1'b0;
        #1;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);
        @(posedge CLK); #1;

        // Fill the whole memory through the CPU port.
        for (int i = 0; i < 256; i++) cpu_store(8'(i), 8'($urandom));
        check_mem_image("preload");

        // Plain copy of 4 bytes: done exactly 9 cycles after the start edge.
        for (int i = 0; i < 4; i++) cpu_store(8'h10 + 8'(i), pat[i]);
        run_xfer(8'h10, 8'h40, 8'd4, 0, 0, 0, 0, 9, "copy4");
        for (int i = 0; i < 4; i++) check("copy4_dst", mem[8'h40 + 8'(i)], pat[i]);

        // Same copy with a 3-cycle CPU burst (store 0x5A to 0x80) mid-transfer.
        for (int i = 0; i < 4; i++) cpu_store(8'h40 + 8'(i), 8'h00);
        run_xfer(8'h10, 8'h40, 8'd4, 0, 3, 3, 0, 12, "stall3");
        check("stall3_cpu_byte", mem[8'h80], 8'h5A);
        for (int i = 0; i < 4; i++) check("stall3_dst", mem[8'h40 + 8'(i)], pat[i]);

        // Zero-length transfer: done in the first cycle, no memory write.
        run_xfer(8'h10, 8'h60, 8'd0, 0, 0, 0, 0, 1, "len0");

        // Forward overlap across the address wrap.
        cpu_store(8'hFE, 8'h11);
        cpu_store(8'hFF, 8'h22);
        cpu_store(8'h00, 8'h33);
        run_xfer(8'hFE, 8'hFF, 8'd3, 0, 0, 0, 0, 7, "wrap");
        check("wrap_ff", mem[8'hFF], 8'h11);
        check("wrap_00", mem[8'h00], 8'h11);
        check("wrap_01", mem[8'h01], 8'h11);

        // A second start during cycle 2 of a transfer is ignored.
        for (int i = 0; i < 4; i++) cpu_store(8'h10 + 8'(i), pat[i]);
        run_xfer(8'h10, 8'h50, 8'd4, 0, 0, 0, 2, 9, "restart");

        // Reset during the WRITE of byte 2: aborts silently, byte 1 stays.
        for (int i = 0; i < 4; i++) cpu_store(8'h40 + 8'(i), 8'h00);
        srcAddr = 8'h10;
        dstAddr = 8'h40;
        len     = 8'd4;
        start   = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("abort_busy_pre", busy, 1'b1);
        check("abort_wr_op_pre", memOp, 1'b1);
        RST_N = 1'b0;
        #1;
        check("abort_memop", memOp, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        #1;
        check("abort_after_busy", busy, 1'b0);
        check("abort_after_done", done, 1'b0);
        check("abort_byte1", mem[8'h40], 8'hA1);
        check("abort_byte2", mem[8'h41], 8'h00);
        check("abort_byte3", mem[8'h42], 8'h00);
        ref_mem[8'h40] = 8'hA1;
        @(posedge CLK); #1;
        check("abort_idle_done", done, 1'b0);
        run_xfer(8'h10, 8'h40, 8'd4, 0, 0, 0, 0, 9, "after_abort");

        // Random transfers with random CPU traffic and stray start pulses.
        for (int t = 0; t < 20; t++) begin
            run_xfer(8'($urandom), 8'($urandom), 8'($urandom_range(40)),
                     35, 0, 0, int'($urandom_range(1, 6)), -1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_dma_ctrl.md
Name: dmem_dma_ctrl

Overview:
Block-move engine and port arbiter in front of the single-port 256x8 data memory. The CPU keeps the memory port, and on any cycle it requests the port, the CPU has absolute priority. The DMA side copies a block of bytes from a source to a destination region, one byte per READ/WRITE pair, using cycles the CPU leaves idle. It sits between the single-cycle CPU's load/store path and the data memory: combinational read, write on posedge.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, memory data width
LEN_W, 8, transfer length width; len=0 means no transfer

Ports:
CLK  in  1  system clock; all state updates on posedge
RST_N  in  1  synchronous reset, active-low
cpuReq  in  1  CPU uses the memory this cycle (load or store)
cpuAddr  in  ADDR_W  CPU address
cpuDataIn  in  DATA_W  CPU store data
cpuMemOp  in  1  CPU op: 1 write, 0 read
cpuDataOut  out  DATA_W  read data to CPU; always equals memDataOut
start  in  1  one-cycle DMA request; sampled only in IDLE
srcAddr  in  ADDR_W  DMA source base; latched on accepted start
dstAddr  in  ADDR_W  DMA destination base; latched on accepted start
len  in  LEN_W  byte count; latched on accepted start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on completion
memAddr  out  ADDR_W  to data memory address
memDataIn  out  DATA_W  to data memory write data
memOp  out  1  to data memory write enable
memDataOut  in  DATA_W  from data memory; combinational read of memAddr

Behaviour:
- States: IDLE, READ, WRITE, DONE. Registers: curSrc, curDst, remaining (LEN_W), buffer (DATA_W).
- Reset (RST_N=0 at posedge): state <= IDLE; curSrc, curDst, remaining and buffer <= 0.
- During reset and in the cycle after it: busy=0, done=0.
- memOp is forced to 0 while RST_N=0, so no memory write happens in any reset cycle.
- Port ownership: the CPU owns the port when cpuReq=1 or state is IDLE or DONE.
  - memAddr = cpuAddr, memDataIn = cpuDataIn, memOp = cpuMemOp & cpuReq.
- DMA owns the port when cpuReq=0 and state is READ or WRITE.
  - READ: memAddr=curSrc, memOp=0.
  - WRITE: memAddr=curDst, memDataIn=buffer, memOp=1.
- IDLE:
  - start=1 latches srcAddr, dstAddr and len.
  - len=0 -> next state DONE; otherwise -> READ.
  - start=0 -> stay in IDLE.
- READ:
  - cpuReq=1 -> stall; no register changes.
  - Else buffer <= memDataOut, -> WRITE.
- WRITE:
  - cpuReq=1 -> stall.
  - Else the byte is written; curSrc++, curDst++ (wrap 0xFF->0x00); remaining--.
  - Next state DONE if remaining==1, else READ.
- DONE: done=1 for exactly this cycle; -> IDLE unconditionally.
- start while busy=1 is ignored; it is not queued.
- Latency without contention: an accepted start at edge k finishes with done high in cycle k+1+2*len. With len=0, done is high in cycle k+1.
- Each stalled cycle adds exactly 1 cycle of latency. The CPU never sees a stall and never loses a cycle.
- Overlapping regions copy strictly forward, byte by byte. Example: dst=src+1 propagates the first byte through the whole block. This is defined behaviour, not an error.
- Reset mid-transfer: the transfer aborts with no done pulse. Bytes already written remain written.
- CPU writes into the DMA region during a transfer are not detected. The ordering per byte is:
  - a CPU write to curSrc before its READ is copied;
  - a CPU write to curDst after its WRITE persists.

Test Plan:
- Preload mem[0x10..0x13]=A1,B2,C3,D4; start src=0x10, dst=0x40, len=4, cpuReq=0 -> done high exactly 9 cycles after the start edge; mem[0x40..0x43]=A1,B2,C3,D4; busy high for those 9 cycles.
- Same copy with cpuReq=1 for 3 cycles mid-transfer (CPU store 0x5A to 0x80 in one of them) -> done delayed to 12 cycles; mem[0x80]=0x5A; destination bytes still correct; memOp driven by the CPU only during its cycles.
- start with len=0 -> done pulses in the cycle after start; memOp stays 0; busy high for 1 cycle.
- src=0xFE, dst=0xFF, len=3 with mem[0xFE]=11, mem[0xFF]=22, mem[0x00]=33 -> forward-overlap plus wrap: mem[0xFF]=11, mem[0x00]=11, mem[0x01]=11.
- Pulse start again in cycle 2 of a len=4 transfer -> ignored: single done pulse, 9-cycle timing unchanged.
- Assert RST_N=0 during the WRITE of byte 2 of a len=4 copy -> no write in that cycle; state IDLE; busy=0; no done pulse. Only byte 1 of the destination is updated, and a new start afterwards is accepted normally.
